load_store_unit: RTL
====================

# load_store_unit

Memory-access stage sitting directly downstream of the core's ALU/decode and upstream of the four byte-wide DMem banks. It accepts one load/store request at a time (MIPS opcode, byte address, store data, destination register) and drives per-lane write enables with lane-replicated store data. For loads, it waits out the synchronous DMem read latency, then extracts and sign/zero-extends the addressed byte, halfword or word. Results return over a valid/ready response port toward register writeback.

## Interface
- `ADDR_W`, default 8: byte-address width.
- `DMEM_LAT`, default 1: DMem read latency in cycles (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept.
- `req_op` in 6: instr[31:26] (LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011).
- `req_addr` in ADDR_W: byte address (ALU result).
- `req_wdata` in 32: store data (rt value).
- `req_rd` in 5: load destination register.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 32: extended load data; 0 for stores/errors.
- `rsp_rd` out 5: echo of req_rd.
- `rsp_we` out 1: 1 only for an error-free load.
- `rsp_err` out 1: misaligned address or unsupported opcode.
- `dmem_addr` out ADDR_W-2: word index, req_addr[ADDR_W-1:2].
- `dmem_wr` out 4: per-lane write enable; lane b = byte address b mod 4 (little-endian, lane 0 = bits 7:0).
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_rdata` in 32: concatenated bank outputs {bank3..bank0}.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- `req_ready` = (state==IDLE).
- Accept on `req_valid & req_ready`: register op/addr/wdata/rd.
- Error check at accept:
  - LH/LHU/SH with addr[0]≠0 → error.
  - LW/SW with addr[1:0]≠0 → error.
  - Any other opcode → error.
  - Error → RESP with rsp_err=1, rsp_we=0, rsp_rdata=0. No DMem access.
- No error → ACCESS, for exactly one cycle. dmem_addr is driven. For stores, dmem_wr is:
  - SB: 1<<addr[1:0].
  - SH: addr[1] ? 1100 : 0011.
  - SW: 1111.
- dmem_wdata:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- ACCESS → RESP for stores; ACCESS → WAIT for loads. WAIT holds dmem_addr for DMEM_LAT cycles via a down-counter.
- Last WAIT cycle: capture the lane-selected, extended dmem_rdata into rsp_rdata.
  - LB/LBU: byte at addr[1:0], sign-/zero-extended.
  - LH/LHU: half at addr[1], sign-/zero-extended.
  - LW: full word.
- RESP: rsp_valid=1 with all rsp_* stable until rsp_ready. On handshake → IDLE.
- dmem_wr is 0000 in every state except ACCESS-with-store.

## Timing
- All outputs are registered except req_ready.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_rd=0, rsp_we=0, rsp_err=0, dmem_addr=0, dmem_wr=0000, dmem_wdata=0.
- Latency is counted from the accept edge, to the first cycle rsp_valid=1:
  - Store: 2 cycles.
  - Load: 2+DMEM_LAT cycles.
  - Error: 1 cycle.
- There is no accept in the same cycle as a response handshake. Minimum spacing is store 3, load 3+DMEM_LAT cycles.
- `req_valid` while busy: ignored (not accepted, no side effect).
- `rsp_ready` held low: stall indefinitely in RESP; no DMem activity.
- `rst` mid-operation: immediate return to reset values. A store in ACCESS whose edge has not yet occurred is not written; a pending response is discarded.
- Address wrap: dmem_addr is the truncated word index. No range error.

## Structure
- Shared package/header `mips_defs`:
  - opcode constants OP_LB..OP_SW.
  - state encodings.
  - DMEM_LAT default.
- One combinational sub-module, `lsu_load_align`: inputs op, addr[1:0], rdata; output extended 32-bit value. It is reused by future core stages.
- FSM, counter and store-lane logic stay in the top module.

## Test plan
- Reset: assert rst during WAIT → same cycle req_ready=1, rsp_valid=0, dmem_wr=0000; no response after release.
- SW addr 0x08, wdata 0xDEADBEEF → one cycle dmem_addr=2, dmem_wr=1111, dmem_wdata=0xDEADBEEF; next cycle rsp_valid=1, rsp_we=0, rsp_err=0.
- SB addr 0x0B, wdata 0x000000A5 → dmem_wr=1000, dmem_wdata=0xA5A5A5A5. Then LB 0x0B with dmem_rdata 0xA5000000 → rsp_rdata=0xFFFFFFA5, rsp_we=1, rsp_rd echoed. LBU → 0x000000A5.
- LH addr 0x0E with dmem_rdata 0x80011234 → 0xFFFF8001. LHU → 0x00008001. LW addr 0x0C → 0x80011234, rsp_valid 3 cycles after accept.
- LW addr 0x05, then op 0x23→0x3F (unsupported) → each rsp_err=1, rsp_we=0, dmem_wr stays 0000, rsp_valid 1 cycle after accept.
- Hold rsp_ready=0 for 4 cycles with req_valid=1 → rsp_* stable, req_ready=0, no second accept; after handshake, next request accepted the following cycle.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS memory-op definitions: opcodes, LSU state encoding and
// the opcode/alignment helpers used by the load/store datapath.
package mips_defs;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam int DMEM_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  // Unknown opcodes and misaligned halfword/word accesses are both errors.
  function automatic logic op_err(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1'b0;
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return |off;
      default:              return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_SB:   return 4'b0001 << off;
      OP_SH:   return off[1] ? 4'b1100 : 4'b0011;
      OP_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   return {4{wd[7:0]}};
      OP_SH:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: selects the addressed byte/half of a DMem
// word and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import mips_defs::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_op)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'd0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of four byte-wide DMem banks;
// drives lane enables for stores and aligns load data after DMem latency.
module load_store_unit
  import mips_defs::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DMEM_LAT = DMEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic              rsp_we,
  output logic              rsp_err,
  output logic [ADDR_W-3:0] dmem_addr,
  output logic [3:0]        dmem_wr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata
);

  localparam int CW = $clog2(DMEM_LAT + 1);

  lsu_state_t   r_state;
  logic [5:0]   r_op;
  logic [1:0]   r_off;
  logic [CW-1:0] r_cnt;
  logic         w_err;
  logic [31:0]  w_ld;

  assign req_ready = (r_state == ST_IDLE);
  assign w_err     = op_err(req_op, req_addr[1:0]);

  lsu_load_align u_align (
    .i_op   (r_op),
    .i_off  (r_off),
    .i_rdata(dmem_rdata),
    .o_data (w_ld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_rd     <= '0;
      rsp_we     <= 1'b0;
      rsp_err    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wr    <= '0;
      dmem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_op      <= req_op;
          r_off     <= req_addr[1:0];
          rsp_rd    <= req_rd;
          rsp_rdata <= '0;
          rsp_err   <= w_err;
          rsp_we    <= !w_err && op_is_load(req_op);
          if (w_err) begin
            r_state   <= ST_RESP;
            rsp_valid <= 1'b1;
          end else begin
            r_state   <= ST_ACCESS;
            dmem_addr <= req_addr[ADDR_W-1:2];
            // Enables and lane data are registered so they line up with ACCESS.
            if (op_is_store(req_op)) begin
              dmem_wr    <= store_mask(req_op, req_addr[1:0]);
              dmem_wdata <= store_data(req_op, req_wdata);
            end
          end
        end
        ST_ACCESS: begin
          dmem_wr <= '0;
          if (op_is_store(r_op)) begin
            r_state   <= ST_RESP;
            rsp_valid <= 1'b1;
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= CW'(DMEM_LAT);
          end
        end
        ST_WAIT: begin
          if (r_cnt == CW'(1)) begin
            rsp_rdata <= w_ld;
            rsp_valid <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
